// File: rtl/overlap_pkg.sv
// overlap_pkg: scheduler state type and tile-geometry helpers
package overlap_pkg;
  typedef enum logic [1:0] {IDLE, RUN, WRAP, DRAIN} state_t;
  function automatic int col_w(input int stride, input int core_in, input int kernel);
    return stride * (core_in - 1) + kernel;
  endfunction
  function automatic int cols_per_tile(input int stride, input int core_in, input int kernel);
    return col_w(stride, core_in, kernel) + core_in * stride;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/prsc_out_fifo.sv
// prsc_out_fifo: first-word-fall-through FIFO with occupancy count
module prsc_out_fifo
  import overlap_pkg::*;
#(
  parameter int W = 49,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr <= '0;
      rd <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wr <= wr + AW'(1);
      if (pop_i) rd <= rd + AW'(1);
      count_o <= count_o + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push_i && !pop_i && count_o == CW'(DEPTH)));
  end
  assign valid_o = count_o != '0;
  assign data_o = valid_o ? mem[rd] : '0;
endmodule

// File: rtl/overlap_prsc_sched.sv
// overlap_prsc_sched: joins core columns, paces the overlap processor and buffers its columns
module overlap_prsc_sched
  import overlap_pkg::*;
#(
  parameter int PIX_WIDTH = 8,
  parameter int SIZE_OF_EACH_CORE_INPUT = 2,
  parameter int SIZE_OF_EACH_KERNEL = 3,
  parameter int STRIDE = 1,
  parameter int TILES_PER_FRAME = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int COL_W = col_w(STRIDE, SIZE_OF_EACH_CORE_INPUT, SIZE_OF_EACH_KERNEL),
  localparam int COLS_PER_TILE = cols_per_tile(STRIDE, SIZE_OF_EACH_CORE_INPUT, SIZE_OF_EACH_KERNEL),
  localparam int OUT_W = PIX_WIDTH * COLS_PER_TILE,
  localparam int DW = PIX_WIDTH * COL_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       core_valid_i,
  input  logic [DW-1:0]    core_data_0_i,
  input  logic [DW-1:0]    core_data_1_i,
  input  logic [DW-1:0]    core_data_2_i,
  input  logic [DW-1:0]    core_data_3_i,
  output logic [3:0]       core_ready_o,
  output logic             prsc_en_o,
  output logic             prsc_valid_o,
  output logic [DW-1:0]    prsc_data_0_o,
  output logic [DW-1:0]    prsc_data_1_o,
  output logic [DW-1:0]    prsc_data_2_o,
  output logic [DW-1:0]    prsc_data_3_o,
  input  logic [OUT_W-1:0] prsc_column_i,
  input  logic             prsc_tile_valid_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             tile_done_o,
  output logic             frame_done_o,
  output logic             err_o
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int KW = $clog2(COLS_PER_TILE);
  localparam int TW = $clog2(TILES_PER_FRAME + 1);
  state_t state, state_n;
  logic [KW-1:0] col;
  logic [TW-1:0] tile;
  logic [CW-1:0] fifo_count;
  logic [1:0] inflight;
  logic rdy, hs, last_col, last_tile, drained, prsc_last, cap, cap_last;
  assign inflight = 2'(prsc_valid_o) + 2'(cap);
  assign rdy = state == RUN && int'(fifo_count) + int'(inflight) < FIFO_DEPTH;
  assign core_ready_o = {4{rdy}};
  assign hs = &core_valid_i && rdy;
  assign last_col = col == KW'(COLS_PER_TILE - 1);
  assign last_tile = tile == TW'(TILES_PER_FRAME - 1);
  assign drained = inflight == 2'd0 && fifo_count == '0;
  assign busy_o = state != IDLE;
  assign prsc_en_o = busy_o;
  assign tile_done_o = state == WRAP;
  assign frame_done_o = state == DRAIN && drained;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start_i ? RUN : IDLE) :
              state == RUN  ? (hs && last_col ? WRAP : RUN) :
              state == WRAP ? (last_tile ? DRAIN : RUN) :
                              (drained ? IDLE : DRAIN);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      col <= '0;
      tile <= '0;
      prsc_valid_o <= 1'b0;
      prsc_last <= 1'b0;
      prsc_data_0_o <= '0;
      prsc_data_1_o <= '0;
      prsc_data_2_o <= '0;
      prsc_data_3_o <= '0;
      cap <= 1'b0;
      cap_last <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      prsc_valid_o <= hs;
      prsc_last <= hs && last_col;
      cap <= prsc_valid_o;
      cap_last <= prsc_last;
      if (state == IDLE && start_i) begin
        col <= '0;
        tile <= '0;
      end
      if (hs) begin
        col <= last_col ? '0 : col + KW'(1);
        prsc_data_0_o <= core_data_0_i;
        prsc_data_1_o <= core_data_1_i;
        prsc_data_2_o <= core_data_2_i;
        prsc_data_3_o <= core_data_3_i;
      end
      if (state == WRAP) tile <= tile + TW'(1);
      if (prsc_tile_valid_i != (cap && cap_last)) err_o <= 1'b1;
    end
  end
  prsc_out_fifo #(.W(OUT_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(cap),
    .data_i({cap_last, prsc_column_i}),
    .pop_i(out_valid_o && out_ready_i),
    .data_o({out_last_o, out_data_o}),
    .valid_o(out_valid_o),
    .count_o(fifo_count)
  );
endmodule

// File: tb/tb_overlap_prsc_sched.sv
// tb_overlap_prsc_sched: scoreboard bench with a behavioural overlap-processor model
module tb_overlap_prsc_sched;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1, early = 1'b0;
  logic [3:0] cv = '0;
  logic [31:0] cd [4];
  logic [3:0] core_ready;
  logic prsc_en, prsc_valid, out_valid, out_last, busy, tile_done, frame_done, err;
  logic [31:0] pd0, pd1, pd2, pd3;
  logic [47:0] pcol, out_data;
  logic ptv, tv_q;
  int mcnt, cyc, tests, fails, fd_cnt, hs_cnt;
  logic [48:0] sb [$];
  int td_q [$];
  always #5 clk = ~clk;
  overlap_prsc_sched dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .core_valid_i(cv),
    .core_data_0_i(cd[0]), .core_data_1_i(cd[1]), .core_data_2_i(cd[2]), .core_data_3_i(cd[3]),
    .core_ready_o(core_ready), .prsc_en_o(prsc_en), .prsc_valid_o(prsc_valid),
    .prsc_data_0_o(pd0), .prsc_data_1_o(pd1), .prsc_data_2_o(pd2), .prsc_data_3_o(pd3),
    .prsc_column_i(pcol), .prsc_tile_valid_i(ptv), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .busy_o(busy), .tile_done_o(tile_done), .frame_done_o(frame_done), .err_o(err)
  );
  function automatic logic [31:0] gen(input logic [7:0] tag, input int k, input int c);
    return {tag, 8'(k), 8'(c), 8'(k * 7 + c * 3)};
  endfunction
  function automatic logic [47:0] proc(input logic [31:0] a, b, c, d);
    return {a[15:0] ^ b[15:0], c[15:0] + d[15:0], d[31:16]};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pcol <= '0;
      tv_q <= 1'b0;
      mcnt <= 0;
    end else begin
      tv_q <= prsc_valid && mcnt == 5;
      if (prsc_valid) begin
        pcol <= proc(pd0, pd1, pd2, pd3);
        mcnt <= mcnt == 5 ? 0 : mcnt + 1;
      end
    end
  end
  assign ptv = early ? (prsc_valid && mcnt == 5) : tv_q;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_col: got %0h expected nothing", {out_last, out_data});
        end else check("out_col", 64'({out_last, out_data}), 64'(sb.pop_front()));
      end
      if (tile_done) td_q.push_back(cyc);
      if (frame_done) fd_cnt++;
      if (&cv && core_ready[0]) hs_cnt++;
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_zero", 64'(|{core_ready, prsc_en, prsc_valid, pd0, pd1, pd2, pd3, out_valid,
                              out_data, out_last, busy, tile_done, frame_done, err}), 64'(0));
  endtask
  task automatic run_frame(input logic [7:0] tag, input int stall_col, input int abort_col);
    int fd0, w;
    for (int k = 0; k < 24; k++) begin
      logic l = (k % 6 == 5);
      sb.push_back({l, proc(gen(tag, k, 0), gen(tag, k, 1), gen(tag, k, 2), gen(tag, k, 3))});
    end
    fd0 = fd_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k == abort_col) begin
        cv = '0;
        do_reset();
        return;
      end
      for (int c = 0; c < 4; c++) cd[c] = gen(tag, k, c);
      if (k == stall_col) begin
        cv = 4'b1011;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          #1 check("stall_gap", 64'(prsc_valid), 64'(0));
        end
      end
      cv = 4'hF;
      w = 0;
      #1;
      while (!core_ready[0] && w < 200) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (w >= 200) begin
        check("hs_timeout", 64'(1), 64'(0));
        cv = '0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    cv = '0;
    w = 0;
    while (fd_cnt == fd0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("frame_timeout", 64'(fd_cnt == fd0), 64'(0));
    repeat (3) @(negedge clk);
    check("drain", 64'(sb.size()), 64'(0));
  endtask
  initial begin
    int fdb, hb;
    for (int c = 0; c < 4; c++) cd[c] = '0;
    do_reset();
    td_q.delete();
    fdb = fd_cnt;
    run_frame(8'h11, -1, -1);
    check("tile_count", 64'(td_q.size()), 64'(4));
    if (td_q.size() == 4)
      for (int i = 1; i < 4; i++) check("tile_gap", 64'(td_q[i] - td_q[i-1]), 64'(7));
    check("frame_count", 64'(fd_cnt - fdb), 64'(1));
    check("err_clean", 64'(err), 64'(0));
    check("idle", 64'(busy), 64'(0));
    run_frame(8'h22, 8, -1);
    check("err_stall", 64'(err), 64'(0));
    out_ready = 1'b0;
    hb = hs_cnt;
    fork
      run_frame(8'h33, -1, -1);
      begin
        repeat (20) @(negedge clk);
        #2 check("credit_hs", 64'(hs_cnt - hb), 64'(4));
        check("credit_ready", 64'(core_ready), 64'(0));
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    early = 1'b1;
    run_frame(8'h44, -1, -1);
    check("err_set", 64'(err), 64'(1));
    repeat (10) @(negedge clk);
    check("err_sticky", 64'(err), 64'(1));
    early = 1'b0;
    do_reset();
    run_frame(8'h55, -1, 15);
    run_frame(8'h66, -1, -1);
    fdb = fd_cnt;
    fork
      run_frame(8'h77, -1, -1);
      begin
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("one_frame_done", 64'(fd_cnt - fdb), 64'(1));
    check("err_final", 64'(err), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
